// File: rtl/lsu_stage.sv
// ============================================================================
// lsu_stage
// ----------------------------------------------------------------------------
// Load/store stage of a simple in-order pipeline. Each operation is accepted
// from upstream, held while a memory request is presented, and then offered
// downstream until it is taken. Only one operation is in flight at a time.
//
// Loads return the addressed byte/half/word, shifted down and sign- or
// zero-extended. Stores issue exactly one lane-shifted, byte-masked write and
// return zero. Non-memory ops pass in_wdata straight through as the result.
//
// Parameter
//   LATENCY      cycles a memory request is held before read data is
//                sampled (1..15)
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_*         upstream handshake (in_valid/in_ready) plus operation
//                fields: address, store/pass-through data, op class, size,
//                unsigned flag, destination register tag
//   out_*        downstream handshake (out_valid/out_ready) plus result
//                data, destination tag and misaligned-access flag
//   mem_*        word-aligned memory port: request valid, read/write
//                addresses, combinational read data, write enable,
//                lane-shifted write data and byte mask
//
// Build option
//   LSU_MISALIGN_CHECK_EN  when defined, misaligned halves/words skip the
//                memory request and respond at once with out_err = 1.
//                When undefined, out_err stays 0 and the offset is
//                truncated to the access size instead.
// ============================================================================
module lsu_stage #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_err,
    output logic        mem_valid,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsuState_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    lsuState_t   r_state;
    lsuState_t   w_nextState;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_isStore;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [4:0]  r_rd;
    logic [3:0]  r_cnt;
    logic        r_wrPending;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_isMem;
    logic        w_skipReq;
    logic [1:0]  w_offset;
    logic [31:0] w_shifted;
    logic [31:0] w_loadData;
    logic [3:0]  w_mask4;

    assign w_isMem = in_is_load | in_is_store;

`ifdef LSU_MISALIGN_CHECK_EN
    logic w_misaligned;

    // Misalignment is judged on the incoming op so that a bad access can go
    // straight to the response without ever touching the memory port.
    always_comb begin
        w_misaligned = 1'b0;
        case (in_size)
            2'b01:   w_misaligned = in_addr[0];
            2'b10,
            2'b11:   w_misaligned = |in_addr[1:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_skipReq = w_isMem & w_misaligned;
`else
    assign w_skipReq = 1'b0;
`endif

    // Byte offset actually used for lane steering. Halves ignore addr[0] and
    // words ignore the offset entirely, so an unchecked misaligned access
    // simply lands on the enclosing aligned half/word.
    always_comb begin
        w_offset = 2'b00;
        case (r_size)
            2'b00:   w_offset = r_addr[1:0];
            2'b01:   w_offset = {r_addr[1], 1'b0};
            default: w_offset = 2'b00;
        endcase
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend
    // bytes and halves according to the unsigned flag.
    always_comb begin
        w_shifted  = mem_rdata >> {w_offset, 3'b000};
        w_loadData = w_shifted;
        case (r_size)
            2'b00: w_loadData = r_unsigned ? {24'd0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01: w_loadData = r_unsigned ? {16'd0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_loadData = w_shifted;
        endcase
    end

    // Byte enables for the store, before lane shifting.
    always_comb begin
        w_mask4 = 4'b1111;
        case (r_size)
            2'b00:   w_mask4 = 4'b0001;
            2'b01:   w_mask4 = 4'b0011;
            default: w_mask4 = 4'b1111;
        endcase
    end

    assign mem_raddr = {r_addr[31:2], 2'b00};
    assign mem_waddr = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata << {w_offset, 3'b000};
    assign mem_wmask = mem_wen ? {4'b0000, w_mask4 << w_offset} : 8'h00;

    assign out_rdata = r_rdata;
    assign out_rd    = r_rd;
    assign out_err   = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake/memory strobes. The write strobe is qualified
    // by r_wrPending so a store writes exactly once even when the request is
    // held for several cycles.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        mem_valid   = 1'b0;
        mem_wen     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = (w_isMem && !w_skipReq) ? REQ : RESP;
                end
            end
            REQ: begin
                mem_valid = 1'b1;
                mem_wen   = r_wrPending;
                if (r_cnt == 4'd0) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Operation registers. Everything is captured on accept; the result is
    // preset there for stores (zero), skipped misaligned ops (zero) and
    // non-memory ops (pass-through), and overwritten by load data when the
    // request counter expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_isStore   <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_rd        <= 5'd0;
            r_cnt       <= 4'd0;
            r_wrPending <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_addr      <= in_addr;
                        r_wdata     <= in_wdata;
                        r_isStore   <= in_is_store;
                        r_size      <= in_size;
                        r_unsigned  <= in_unsigned;
                        r_rd        <= in_rd;
                        r_cnt       <= CNT_INIT;
                        r_wrPending <= in_is_store & ~w_skipReq;
                        r_err       <= w_skipReq;
                        r_rdata     <= w_isMem ? 32'd0 : in_wdata;
                    end
                end
                REQ: begin
                    r_wrPending <= 1'b0;
                    if (r_cnt == 4'd0) begin
                        if (!r_isStore) begin
                            r_rdata <= w_loadData;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// ============================================================================
// tb_lsu_stage
// ----------------------------------------------------------------------------
// Bench for lsu_stage with LATENCY = 3. A small word memory answers the DUT's
// memory port. A behavioural model predicts, from the cycle an op is
// accepted, when the request and response phases occur and what data they
// carry; a compare process checks the DUT against it every cycle. Directed
// ops with literal expectations come first, then randomized traffic with
// random downstream back-pressure and occasional resets.
// ============================================================================
module tb_lsu_stage;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_is_load;
    logic        in_is_store;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_err;
    logic        mem_valid;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    lsu_stage #(.LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_is_load  (in_is_load),
        .in_is_store (in_is_store),
        .in_size     (in_size),
        .in_unsigned (in_unsigned),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rdata   (out_rdata),
        .out_rd      (out_rd),
        .out_err     (out_err),
        .mem_valid   (mem_valid),
        .mem_raddr   (mem_raddr),
        .mem_waddr   (mem_waddr),
        .mem_rdata   (mem_rdata),
        .mem_wen     (mem_wen),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask)
    );

    // Environment memory: 16 words at 0x80000000, written by the DUT.
    logic [31:0] envMem [16];
    assign mem_rdata = envMem[mem_raddr[5:2]];

    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) envMem[mem_waddr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model. Timeline of an accepted op, counted in cycles after
    // the accepting edge: memory ops hold the request for LAT cycles (write
    // only in the first), then respond; non-memory and rejected misaligned
    // ops respond immediately. The response lasts until out_ready.
    // ------------------------------------------------------------------------
    int          cyc = 0;
    logic        mReady = 1'b0;
    logic        mBusy = 1'b0;
    int          mAcc;
    int          mRespAt;
    logic        mMemPhase;
    logic        mIsStore;
    logic        mErr;
    logic [31:0] mAddr;
    logic [31:0] mRdata;
    logic [31:0] mWdata;
    logic [7:0]  mMask;
    logic [4:0]  mRd;
    logic [31:0] modelMem [16];

    task automatic modelAccept();
        int          off;
        int          nBytes;
        longint      v;
        logic [31:0] w;
        logic        isMem;
        isMem    = in_is_load | in_is_store;
        mIsStore = in_is_store;
        case (in_size)
            2'b00:   begin off = int'(in_addr[1:0]); nBytes = 1; end
            2'b01:   begin off = in_addr[1] ? 2 : 0; nBytes = 2; end
            default: begin off = 0; nBytes = 4; end
        endcase
        mErr = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if (isMem && ((in_size == 2'b01 && in_addr[0]) || (in_size[1] && in_addr[1:0] != 2'b00)))
            mErr = 1'b1;
`endif
        mAddr  = {in_addr[31:2], 2'b00};
        mRd    = in_rd;
        mAcc   = cyc + 1;
        mWdata = 32'd0;
        mMask  = 8'd0;
        if (mErr) begin
            mMemPhase = 1'b0;
            mRdata    = 32'd0;
            mRespAt   = mAcc;
        end else if (!isMem) begin
            mMemPhase = 1'b0;
            mRdata    = in_wdata;
            mRespAt   = mAcc;
        end else begin
            mMemPhase = 1'b1;
            mRespAt   = mAcc + LAT;
            if (in_is_store) begin
                mWdata = in_wdata << (8 * off);
                mMask  = 8'(((1 << nBytes) - 1) << off);
                for (int b = 0; b < 4; b++) begin
                    if (mMask[b]) modelMem[in_addr[5:2]][8*b +: 8] = mWdata[8*b +: 8];
                end
                mRdata = 32'd0;
            end else begin
                w = modelMem[in_addr[5:2]];
                v = longint'(w >> (8 * off));
                if (nBytes == 1) begin
                    v = v & 255;
                    if (!in_unsigned && v >= 128) v = v - 256;
                end else if (nBytes == 2) begin
                    v = v & 65535;
                    if (!in_unsigned && v >= 32768) v = v - 65536;
                end
                mRdata = 32'(v);
            end
        end
        mBusy = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mBusy  = 1'b0;
            mReady = 1'b1;
        end else if (mReady) begin
            if (mBusy && cyc >= mRespAt && out_ready) mBusy = 1'b0;
            else if (!mBusy && in_valid) modelAccept();
        end
        cyc++;
    end

    // Per-cycle comparison against the model.
    logic expReq, expOut, expWen;
    always @(negedge clk) begin
        if (mReady) begin
            expReq = mBusy && mMemPhase && (cyc < mRespAt);
            expOut = mBusy && (cyc >= mRespAt);
            expWen = expReq && mIsStore && (cyc == mAcc);
            check("in_ready",  32'(in_ready),  32'(!mBusy));
            check("out_valid", 32'(out_valid), 32'(expOut));
            check("mem_valid", 32'(mem_valid), 32'(expReq));
            check("mem_wen",   32'(mem_wen),   32'(expWen));
            if (expReq) check("mem_raddr", mem_raddr, mAddr);
            else        check("mem_wmask_idle", 32'(mem_wmask), 32'd0);
            if (expWen) begin
                check("mem_waddr", mem_waddr, mAddr);
                check("mem_wdata", mem_wdata, mWdata);
                check("mem_wmask", 32'(mem_wmask), 32'(mMask));
            end
            if (expOut) begin
                check("out_rdata", out_rdata, mRdata);
                check("out_rd",    32'(out_rd), 32'(mRd));
                check("out_err",   32'(out_err), 32'(mErr));
            end
        end
    end

    // Activity counters used by the directed literal checks.
    int          memValidCycles = 0;
    int          wenCycles = 0;
    logic [7:0]  lastMask = 8'd0;
    logic [31:0] lastWdata = 32'd0;
    always @(negedge clk) begin
        if (mem_valid) memValidCycles++;
        if (mem_wen) begin
            wenCycles++;
            lastMask  = mem_wmask;
            lastWdata = mem_wdata;
        end
    end

    // Issue one op from an idle negedge, wait (bounded) for the response,
    // hold out_ready low for 'hold' cycles, then take it.
    task automatic applyStimulus(input logic ld, input logic st, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input int hold,
                                 output logic [31:0] rdata, output logic err, output int lat);
        memValidCycles = 0;
        wenCycles      = 0;
        in_valid    = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_size     = size;
        in_unsigned = uns;
        in_addr     = addr;
        in_wdata    = wdata;
        in_rd       = rd;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("resp_timeout", 32'(out_valid), 32'd1);
        repeat (hold) @(negedge clk);
        rdata     = out_rdata;
        err       = out_err;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    logic [31:0] rdata;
    logic        err;
    int          lat;

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_addr     = 32'd0;
        in_wdata    = 32'd0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_size     = 2'b00;
        in_unsigned = 1'b0;
        in_rd       = 5'd0;
        out_ready   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            envMem[i]   = $urandom;
            modelMem[i] = envMem[i];
        end
        envMem[0]   = 32'h8899AABB;
        modelMem[0] = 32'h8899AABB;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_rdata", out_rdata,      32'd0);
        checkOutput("rst_out_rd",    32'(out_rd),    32'd0);
        checkOutput("rst_out_err",   32'(out_err),   32'd0);
        checkOutput("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        checkOutput("rst_mem_raddr", mem_raddr,      32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed ops");
        // lb 0x80000003 of 0x8899AABB
        applyStimulus(1, 0, 2'b00, 0, 32'h80000003, 32'd0, 5'd1, 0, rdata, err, lat);
        checkOutput("lb_rdata", rdata, 32'hFFFFFF88);
        checkOutput("lb_latency", 32'(lat), 32'(LAT));
        checkOutput("lb_mem_valid_cycles", 32'(memValidCycles), 32'(LAT));

        // lhu 0x80000002
        applyStimulus(1, 0, 2'b01, 1, 32'h80000002, 32'd0, 5'd2, 1, rdata, err, lat);
        checkOutput("lhu_rdata", rdata, 32'h00008899);
        checkOutput("lhu_latency", 32'(lat), 32'(LAT));

        // sb 0xEE at 0x80000001
        applyStimulus(0, 1, 2'b00, 0, 32'h80000001, 32'h000000EE, 5'd3, 0, rdata, err, lat);
        checkOutput("sb_wen_cycles", 32'(wenCycles), 32'd1);
        checkOutput("sb_wmask", 32'(lastMask), 32'h02);
        checkOutput("sb_wdata", lastWdata, 32'h0000EE00);
        checkOutput("sb_rdata", rdata, 32'd0);

        // lbu reads the stored byte back
        applyStimulus(1, 0, 2'b00, 1, 32'h80000001, 32'd0, 5'd4, 0, rdata, err, lat);
        checkOutput("lbu_rdata", rdata, 32'h000000EE);

        // non-memory op held for 3 cycles of back-pressure
        applyStimulus(0, 0, 2'b10, 0, 32'h00000040, 32'h12345678, 5'd5, 3, rdata, err, lat);
        checkOutput("alu_rdata", rdata, 32'h12345678);
        checkOutput("alu_latency", 32'(lat), 32'd0);

        // misaligned lw 0x80000002
        applyStimulus(1, 0, 2'b10, 0, 32'h80000002, 32'd0, 5'd6, 0, rdata, err, lat);
`ifdef LSU_MISALIGN_CHECK_EN
        checkOutput("lw_mis_err", 32'(err), 32'd1);
        checkOutput("lw_mis_rdata", rdata, 32'd0);
        checkOutput("lw_mis_latency", 32'(lat), 32'd0);
        checkOutput("lw_mis_mem_valid", 32'(memValidCycles), 32'd0);
`else
        checkOutput("lw_mis_err", 32'(err), 32'd0);
        checkOutput("lw_mis_rdata", rdata, 32'h8899EEBB);
        checkOutput("lw_mis_latency", 32'(lat), 32'(LAT));
`endif

        // sw interrupted by reset during its request phase
        in_valid    = 1'b1;
        in_is_load  = 1'b0;
        in_is_store = 1'b1;
        in_size     = 2'b10;
        in_addr     = 32'h80000004;
        in_wdata    = 32'hCAFEF00D;
        in_rd       = 5'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wenCycles = 0;
        checkOutput("rstreq_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rstreq_out_valid", 32'(out_valid), 32'd0);
        repeat (LAT + 2) @(negedge clk);
        checkOutput("rstreq_no_wen", 32'(wenCycles), 32'd0);
        checkOutput("rstreq_out_valid_late", 32'(out_valid), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_is_load  = 1'($urandom);
            in_is_store = 1'($urandom);
            in_size     = 2'($urandom);
            in_unsigned = 1'($urandom);
            in_addr     = 32'h80000000 | 32'($urandom_range(0, 63));
            in_wdata    = $urandom;
            in_rd       = 5'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter: LATENCY, default 1, number of cycles a memory request is held before read data is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid / in_ready  input / output  1 / 1  upstream handshake; transfer when both high.
REQ-005 in_addr  input  32  effective address (ALU result).
REQ-006 in_wdata  input  32  store data, or pass-through result for non-memory ops.
REQ-007 in_is_load, in_is_store  input  1 each  op class.
REQ-008 in_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-009 in_unsigned  input  1  zero-extend load (lbu/lhu) when high.
REQ-010 in_rd  input  5  destination register tag, carried to output.
REQ-011 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-012 out_rdata  output  32  extended load data or pass-through value; out_rd  output  5; out_err  output  1  misaligned flag.
REQ-013 mem_valid  output  1; mem_raddr, mem_waddr  output  32  word-aligned (bits [1:0]=0); mem_rdata  input  32  raw word, combinational from memory.
REQ-014 mem_wen  output  1; mem_wdata  output  32  lane-shifted; mem_wmask  output  8  byte enables, bits [7:4] always 0.

Function
REQ-015 FSM states IDLE, REQ, RESP; in_ready SHALL be high iff state is IDLE.
REQ-016 IDLE accept (edge T): register all inputs; load/store -> REQ with counter = LATENCY-1; non-memory op -> RESP with out_rdata = in_wdata.
REQ-017 in_is_load and in_is_store both high: treated as store.
REQ-018 REQ: mem_valid = 1, addresses = {addr[31:2],2'b00} from registers, stable for all REQ cycles.
REQ-019 Store: mem_wen = 1 on the first REQ cycle only (exactly one write per store); mem_wdata = wdata << (8*addr[1:0]); mem_wmask = 0001/0011/1111 << addr[1:0].
REQ-020 Counter decrements each REQ cycle; at zero, sample mem_rdata, go RESP.
REQ-021 Load extraction: shift word right by 8*addr[1:0], then byte/half sign- or zero-extend per in_unsigned; word unchanged.
REQ-022 Store response: out_rdata = 0, out_rd carried.
REQ-023 RESP: out_valid = 1, outputs held stable until out_ready; on out_valid && out_ready -> IDLE; no new accept in the same cycle.
REQ-024 Latency: load/store out_valid first high at T+LATENCY+1; non-memory at T+1.
REQ-025 mem_valid, mem_wen, mem_wmask are 0 outside REQ.

Reset
REQ-026 rst high at an edge: state IDLE; out_valid, out_err, mem_valid, mem_wen = 0; out_rdata, out_rd, mem_wmask, all registered address/data = 0.
REQ-027 Reset mid-REQ or mid-RESP discards the transaction; a write not yet issued SHALL NOT be issued; in_ready = 1 the cycle after reset.

Configuration
REQ-028 Macro LSU_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip REQ (no mem_valid, no write), go directly to RESP at T+1 with out_err = 1, out_rdata = 0.
REQ-029 Macro undefined: out_err tied 0; misaligned access issued with offset truncated (half uses addr[1] only, word uses offset 0).

Verification
REQ-030 LATENCY=1, mem word 0x8899AABB at 0x80000000, lb addr 0x80000003 -> mem_raddr 0x80000000, out_valid at T+2, out_rdata 0xFFFFFF88.
REQ-031 LATENCY=3, lhu addr 0x80000002, same word -> mem_valid high 3 cycles, out_valid at T+4, out_rdata 0x00008899.
REQ-032 sb wdata 0x000000EE addr 0x80000001 -> single mem_wen cycle, mem_wmask 0x02, mem_wdata 0x0000EE00.
REQ-033 Non-memory op in_wdata 0x12345678, out_ready low 3 cycles -> out_rdata held 0x12345678, in_ready low until handshake.
REQ-034 LSU_MISALIGN_CHECK_EN, lw addr 0x80000002 -> no mem_valid, out_err=1 at T+1; rst asserted mid-REQ of sw -> no mem_wen after reset edge, out_valid 0.
